mem_access_unit: RTL and testbench

- Sits between the CPU datapath and the word-wide data_memory; the memory has a combinational read and a synchronous write on posedge clk.
- Converts byte, halfword and word loads/stores into aligned 32-bit word accesses.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Misaligned, out-of-range and invalid-size requests are detected and reported without touching memory.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit in front of a word-wide data memory
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module mem_access_unit #(
  parameter int MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic [29:0] word_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] result_q;
  logic        error_q;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic [31:0] merge_value;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_addr[31:2] >= 30'(MEM_WORDS)) req_err = 1'b1;
  end

  always_comb begin
    byte_sel   = mem_rd[8*lane_q +: 8];
    half_sel   = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_value = mem_rd;
    case (size_q)
      2'b00:   load_value = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   load_value = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: load_value = mem_rd;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the word is written back as read.
  always_comb begin
    merge_value = mem_rd;
    if (size_q == 2'b00) begin
      merge_value[8*lane_q +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merge_value[31:16] = wdata_q[15:0];
    end else begin
      merge_value[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_q   <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            word_q   <= req_addr[31:2];
            lane_q   <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            merged_q <= req_wdata;
            result_q <= '0;
            error_q  <= req_err;
          end
        end
        LOAD:    result_q <= load_value;
        MERGE:   merged_q <= merge_value;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    mem_a      = '0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)              state_next = RESP;
          else if (!req_we)         state_next = LOAD;
          else if (req_size == 2'b10) state_next = WRITE;
          else                      state_next = MERGE;
        end
      end
      LOAD: begin
        mem_a      = {word_q, 2'b00};
        state_next = RESP;
      end
      MERGE: begin
        mem_a      = {word_q, 2'b00};
        state_next = WRITE;
      end
      WRITE: begin
        mem_a      = {word_q, 2'b00};
        mem_we     = 1'b1;
        mem_wd     = merged_q;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = result_q;
        resp_error = error_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset blanks every output in the same cycle, so an in-flight WRITE never commits.
    if (reset) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_error = 1'b0;
      mem_a      = '0;
      mem_we     = 1'b0;
      mem_wd     = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Driver queues expected responses/writes; a monitor compares at each negedge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  mem_access_unit #(.MEM_WORDS(2048)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_a(mem_a),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  assign mem_rd = mem[mem_a[12:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[12:2]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int at; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int at; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int checks = 0;
  int errors = 0;
  logic reset_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      checks++;
      if (req_ready || resp_valid || resp_error || mem_we || resp_rdata != 0 || mem_a != 0 || mem_wd != 0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%0b valid=%0b err=%0b we=%0b rdata=%h a=%h wd=%h, required all zero",
                 req_ready, resp_valid, resp_error, mem_we, resp_rdata, mem_a, mem_wd);
      end
    end else begin
      if (reset_prev) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_reset: got %b, required 1", req_ready);
        end
      end
      if (resp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: cycle %0d rdata=%h err=%b, required no response", cyc, resp_rdata, resp_error);
        end else begin
          resp_t e;
          e = rq.pop_front();
          if (resp_rdata !== e.rdata || resp_error !== e.err || cyc != e.at || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp: got rdata=%h err=%b cycle=%0d ready=%b, required rdata=%h err=%b cycle=%0d ready=0",
                     resp_rdata, resp_error, cyc, req_ready, e.rdata, e.err, e.at);
          end
        end
      end else if (rq.size() != 0 && rq[0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_resp: none by cycle %0d, required at cycle %0d", cyc, rq[0].at);
        void'(rq.pop_front());
      end
      if (mem_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: cycle %0d a=%h wd=%h, required no write", cyc, mem_a, mem_wd);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (mem_a !== w.addr || mem_wd !== w.data || cyc != w.at) begin
            errors++;
            $display("FAIL write: got a=%h wd=%h cycle=%0d, required a=%h wd=%h cycle=%0d",
                     mem_a, mem_wd, cyc, w.addr, w.data, w.at);
          end
        end
      end else if (wq.size() != 0 && wq[0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_write: none by cycle %0d, required at cycle %0d", cyc, wq[0].at);
        void'(wq.pop_front());
      end
    end
    reset_prev = reset;
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_wd, input bit expect_resp, input bit keep_valid);
    int waited = 0;
    int lat;
    resp_t r;
    wr_t   w;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, waited);
      $fatal(1);
    end
    lat = exp_err ? 1 : (!we || size == 2'b10) ? 2 : 3;
    if (expect_resp) begin
      r.rdata = exp_rdata; r.err = exp_err; r.at = cyc + lat;
      rq.push_back(r);
      if (we && !exp_err) begin
        w.addr = {addr[31:2], 2'b00}; w.data = exp_wd; w.at = cyc + lat - 1;
        wq.push_back(w);
      end
    end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 50) begin
      $display("FAIL drain_timeout: %0d responses and %0d writes outstanding, required 0", rq.size(), wq.size());
      $fatal(1);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0, 32'h11223344, 1, 0); drain();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h11223344, 0, 32'h0, 1, 0); drain();
    issue(1, 2'b00, 0, 32'h12, 32'hFFFF_FFA5, 32'h0, 0, 32'h11A53344, 1, 0); drain();
    issue(0, 2'b00, 1, 32'h12, 32'h0, 32'hFFFFFFA5, 0, 32'h0, 1, 0); drain();
    issue(0, 2'b00, 0, 32'h12, 32'h0, 32'h000000A5, 0, 32'h0, 1, 0); drain();
    issue(1, 2'b01, 1, 32'h10, 32'h0000BEEF, 32'h0, 0, 32'h11A5BEEF, 1, 0); drain();
    issue(0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 32'h0, 1, 0); drain();
    issue(0, 2'b01, 0, 32'h12, 32'h0, 32'h000011A5, 0, 32'h0, 1, 0); drain();

    issue(0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 32'h0, 1, 0); drain();
    issue(1, 2'b10, 0, 32'h16, 32'hDEADBEEF, 32'h0, 1, 32'h0, 1, 0); drain();
    issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 32'h0, 1, 0); drain();
    issue(1, 2'b10, 0, 32'h2000, 32'hDEADBEEF, 32'h0, 1, 32'h0, 1, 0); drain();
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h11A5BEEF, 0, 32'h0, 1, 0); drain();

    issue(1, 2'b10, 1, 32'h1FFC, 32'hCAFEF00D, 32'h0, 0, 32'hCAFEF00D, 1, 0); drain();
    issue(0, 2'b00, 1, 32'h1FFF, 32'h0, 32'hFFFFFFCA, 0, 32'h0, 1, 0); drain();

    // Byte store aborted by reset while in MERGE.
    issue(1, 2'b00, 0, 32'h10, 32'h000000FF, 32'h0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h11A5BEEF, 0, 32'h0, 1, 0); drain();

    // Three loads with req_valid held high throughout.
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h11A5BEEF, 0, 32'h0, 1, 1);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 32'h00000011, 0, 32'h0, 1, 1);
    issue(0, 2'b01, 1, 32'h12, 32'h0, 32'h000011A5, 0, 32'h0, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
